// File: rtl/noc_vc_fifo.sv
// Multi-VC first-word-fall-through FIFO: NUM_VC independent queues sharing one write and one read port.
// Flags and counts are combinational from registered pointers; rejected operations set a sticky err.
module noc_vc_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int NUM_VC    = 2,
    parameter int VC_BITS   = 1,
    parameter int AFULL_TH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [VC_BITS-1:0]            wvc,
    input  logic                          winc,
    input  logic [VC_BITS-1:0]            rvc,
    input  logic                          rinc,
    output logic [WIDTH-1:0]              rdata,
    output logic [NUM_VC-1:0]             wfull,
    output logic [NUM_VC-1:0]             wafull,
    output logic [NUM_VC-1:0]             rempty,
    output logic [NUM_VC*(ADDR_BITS+1)-1:0] count,
    output logic                          err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int PW    = ADDR_BITS + 1;
    localparam int AW    = VC_BITS + ADDR_BITS;
    localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_TH);

    logic [WIDTH-1:0] mem [NUM_VC*DEPTH];
    logic [PW-1:0]    wptr [NUM_VC];
    logic [PW-1:0]    rptr [NUM_VC];
    logic [PW-1:0]    occ  [NUM_VC];

    logic          w_full_sel;
    logic          r_empty_sel;
    logic [PW-1:0] w_ptr_sel;
    logic [PW-1:0] r_ptr_sel;
    logic          w_vc_ok;
    logic          r_vc_ok;
    logic          w_acc;
    logic          r_acc;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    always_comb begin
        count  = '0;
        rempty = '0;
        wfull  = '0;
        wafull = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occ[v]             = wptr[v] - rptr[v];
            rempty[v]          = (wptr[v] == rptr[v]);
            wfull[v]           = (wptr[v][ADDR_BITS] != rptr[v][ADDR_BITS]) &&
                                 (wptr[v][ADDR_BITS-1:0] == rptr[v][ADDR_BITS-1:0]);
            wafull[v]          = (occ[v] >= AFULL_LVL);
            count[v*PW +: PW]  = occ[v];
        end
    end

    // Out-of-range VC selects fall back to full/empty so they can never be accepted.
    always_comb begin
        w_full_sel  = 1'b1;
        r_empty_sel = 1'b1;
        w_ptr_sel   = '0;
        r_ptr_sel   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (32'(wvc) == v) begin
                w_full_sel = wfull[v];
                w_ptr_sel  = wptr[v];
            end
            if (32'(rvc) == v) begin
                r_empty_sel = rempty[v];
                r_ptr_sel   = rptr[v];
            end
        end
    end

    assign w_vc_ok = (32'(wvc) < NUM_VC);
    assign r_vc_ok = (32'(rvc) < NUM_VC);
    assign w_acc   = winc && w_vc_ok && !w_full_sel;
    assign r_acc   = rinc && r_vc_ok && !r_empty_sel;
    assign waddr   = {wvc, w_ptr_sel[ADDR_BITS-1:0]};
    assign raddr   = {rvc, r_ptr_sel[ADDR_BITS-1:0]};
    assign rdata   = mem[raddr];

    always_ff @(posedge clk) begin
        if (!rst && w_acc) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_acc && (32'(wvc) == v)) begin
                    wptr[v] <= wptr[v] + 1'b1;
                end
                if (r_acc && (32'(rvc) == v)) begin
                    rptr[v] <= rptr[v] + 1'b1;
                end
            end
            if ((winc && !w_acc) || (rinc && !r_acc)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Bench for noc_vc_fifo: queue model per VC, rdata scoreboard, vector table plus corner sequences.
module tb_noc_vc_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata;
    logic [0:0]  wvc;
    logic        winc;
    logic [0:0]  rvc;
    logic        rinc;
    logic [31:0] rdata;
    logic [1:0]  wfull;
    logic [1:0]  wafull;
    logic [1:0]  rempty;
    logic [11:0] count;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] sb[$];
    logic        m_err;

    always #5 clk = ~clk;

    noc_vc_fifo #(.WIDTH(32), .ADDR_BITS(5), .NUM_VC(2), .VC_BITS(1), .AFULL_TH(4)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .wvc(wvc), .winc(winc),
        .rvc(rvc), .rinc(rinc), .rdata(rdata), .wfull(wfull), .wafull(wafull),
        .rempty(rempty), .count(count), .err(err)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_flags();
        int s0 = q0.size();
        int s1 = q1.size();
        cmp("count0", 32'(count[5:0]), 32'(s0));
        cmp("count1", 32'(count[11:6]), 32'(s1));
        cmp("rempty", 32'(rempty), {30'd0, s1 == 0, s0 == 0});
        cmp("wfull", 32'(wfull), {30'd0, s1 == 32, s0 == 32});
        cmp("wafull", 32'(wafull), {30'd0, s1 >= 28, s0 >= 28});
        cmp("err", 32'(err), 32'(m_err));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic wi, input logic wv, input logic [31:0] wd,
                        input logic ri, input logic rv);
        logic w_ok, r_ok;
        logic [31:0] exp;
        winc = wi; wvc = wv; wdata = wd; rinc = ri; rvc = rv;
        #1;
        w_ok = wi && (qsize(int'(wv)) < 32);
        r_ok = ri && (qsize(int'(rv)) > 0);
        if (r_ok) sb.push_back(rv ? q1[0] : q0[0]);
        if (r_ok) begin
            exp = sb.pop_front();
            cmp("rdata", rdata, exp);
        end
        @(posedge clk);
        if (r_ok) begin
            if (rv) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        if (w_ok) begin
            if (wv) q1.push_back(wd); else q0.push_back(wd);
        end
        if ((wi && !w_ok) || (ri && !r_ok)) m_err = 1'b1;
        @(negedge clk);
        winc = 1'b0; rinc = 1'b0;
        check_flags();
    endtask

    // Reset with a write request pending to show it is ignored.
    task automatic do_reset();
        rst = 1'b1; winc = 1'b1; wvc = 1'b0; wdata = 32'hDEAD; rinc = 1'b1; rvc = 1'b1;
        @(posedge clk);
        q0.delete(); q1.delete(); m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        check_flags();
    endtask

    typedef struct {
        logic        wi;
        logic        wv;
        logic [31:0] wd;
        logic        ri;
        logic        rv;
        logic [5:0]  c0;
        logic [5:0]  c1;
        logic        er;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, 6'd2, 6'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'hB0, 1'b1, 1'b0, 6'd1, 6'd1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 6'd1, 6'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 6'd1, 6'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 6'd0, 6'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 6'd0, 6'd0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 32'hB1, 1'b1, 1'b1, 6'd0, 6'd1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 6'd0, 6'd0, 1'b1};

        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wvc = 1'b0; rvc = 1'b0; wdata = '0; m_err = 1'b0;
        @(negedge clk);
        do_reset();
        cmp("reset_rempty", 32'(rempty), 32'h3);
        cmp("reset_count", 32'(count), 32'h0);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].wi, tbl[i].wv, tbl[i].wd, tbl[i].ri, tbl[i].rv);
            cmp($sformatf("tbl%0d_c0", i), 32'(count[5:0]), 32'(tbl[i].c0));
            cmp($sformatf("tbl%0d_c1", i), 32'(count[11:6]), 32'(tbl[i].c1));
            cmp($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
        end

        // Fill VC0 with 0..31, watching almost-full and full thresholds.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
            if (i == 26) cmp("afull_27", 32'(wafull[0]), 32'd0);
            if (i == 27) cmp("afull_28", 32'(wafull[0]), 32'd1);
            if (i == 30) cmp("full_31", 32'(wfull[0]), 32'd0);
        end
        cmp("full_32", 32'(wfull), 32'h1);
        step(1'b1, 1'b0, 32'h99, 1'b0, 1'b0);
        cmp("overflow_count", 32'(count[5:0]), 32'd32);
        cmp("overflow_err", 32'(err), 32'd1);
        cmp("vc1_empty", 32'(rempty[1]), 32'd1);

        // Drain VC0; scoreboard checks 0..31 in order.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("drained", 32'(rempty[0]), 32'd1);

        // Wrap-around on VC1: three rounds of 40 writes and 40 pops, overlapped.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 60; c++) begin
                step(c < 40, 1'b1, $urandom, c >= 20, 1'b1);
                if (count[11:6] > 6'd32) cmp("wrap_bound", 32'(count[11:6]), 32'd32);
            end
        end
        cmp("wrap_err", 32'(err), 32'd0);
        cmp("wrap_empty", 32'(rempty), 32'h3);

        // Same-cycle write+pop on VC0 with 5, 0 and 32 entries.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(100 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h105, 1'b1, 1'b0);
        cmp("wp5_count", 32'(count[5:0]), 32'd5);
        cmp("wp5_err", 32'(err), 32'd0);
        do_reset();
        step(1'b1, 1'b0, 32'h77, 1'b1, 1'b0);
        cmp("wp0_count", 32'(count[5:0]), 32'd1);
        cmp("wp0_err", 32'(err), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 32'(200 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h55, 1'b1, 1'b0);
        cmp("wp32_count", 32'(count[5:0]), 32'd31);
        cmp("wp32_err", 32'(err), 32'd1);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation with err set and both VCs occupied.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(400 + i), 1'b0, 1'b0);
        cmp("pre_rst_c0", 32'(count[5:0]), 32'd10);
        cmp("pre_rst_c1", 32'(count[11:6]), 32'd3);
        do_reset();
        cmp("rst_count", 32'(count), 32'h0);
        cmp("rst_rempty", 32'(rempty), 32'h3);
        cmp("rst_err", 32'(err), 32'd0);
        step(1'b1, 1'b1, 32'hCAFE, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
